// File: rtl/ntsc_timing_pkg.sv
// Shared constants and types for the NTSC 240p raster timing generator.
package ntsc_timing_pkg;

  localparam int DEF_CLK_DIV       = 5;
  localparam int DEF_H_TOTAL       = 3178;
  localparam int DEF_H_SYNC        = 235;
  localparam int DEF_H_EQ          = 118;
  localparam int DEF_H_ACT_START   = 470;
  localparam int DEF_H_ACT_PIX     = 512;
  localparam int DEF_H_BURST_START = 265;
  localparam int DEF_H_BURST_LEN   = 126;
  localparam int DEF_V_TOTAL       = 262;
  localparam int DEF_V_ACT_START   = 20;
  localparam int DEF_V_ACT_LINES   = 240;

  localparam int H_HALF = DEF_H_TOTAL / 2;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {LT_EQ, LT_VS, LT_NORMAL} line_type_t;

endpackage

// File: rtl/ntsc_timing_if.sv
// Video timing bundle: coordinates, active flag, composite sync, burst gate
// and frame strobe. The generator drives it, the encoder/pattern side reads it.
interface ntsc_timing_if;
  import ntsc_timing_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           active_video;
  logic           sync_n;
  logic           burst_gate;
  logic           frame_start;

  modport master (output x, y, active_video, sync_n, burst_gate, frame_start);
  modport slave  (input  x, y, active_video, sync_n, burst_gate, frame_start);
endinterface

// File: rtl/ntsc_hcount.sv
// Horizontal counter with the pixel divider. x is built by counting divider
// wraps so no divide appears in the datapath; both are held at 0 outside
// the active window so each window starts clean.
module ntsc_hcount
  import ntsc_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_PIX   = DEF_H_ACT_PIX,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int HW          = $clog2(H_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           line_act,
  output logic [HW-1:0]  h_cnt,
  output logic           eol,
  output logic           in_win,
  output logic [X_W-1:0] x_next
);

  localparam int H_ACT_END = H_ACT_START + CLK_DIV * H_ACT_PIX;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]  pix_div;
  logic [X_W-1:0] x_cnt;
  int             h;

  // Decode the current horizontal position.
  always_comb begin
    h      = int'(h_cnt);
    eol    = (h == H_TOTAL - 1);
    in_win = line_act && (h >= H_ACT_START) && (h < H_ACT_END);
    x_next = in_win ? x_cnt : '0;
  end

  // Advance the line counter and the pixel divider / column counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      pix_div <= '0;
      x_cnt   <= '0;
    end else begin
      h_cnt <= eol ? '0 : h_cnt + 1'b1;
      if (!in_win) begin
        pix_div <= '0;
        x_cnt   <= '0;
      end else if (pix_div == DIV_LAST) begin
        pix_div <= '0;
        x_cnt   <= x_cnt + 1'b1;
      end else begin
        pix_div <= pix_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ntsc_timing_gen.sv
// Progressive 262-line NTSC raster timing generator. Outputs are registered
// and describe the counter position of the previous clock.
// Optional feature: define NTSC_TIMING_BURST_EN to generate burst_gate;
// without it burst_gate is held at 0.
module ntsc_timing_gen
  import ntsc_timing_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_EQ          = DEF_H_EQ,
  parameter int H_ACT_START   = DEF_H_ACT_START,
  parameter int H_ACT_PIX     = DEF_H_ACT_PIX,
  parameter int H_BURST_START = DEF_H_BURST_START,
  parameter int H_BURST_LEN   = DEF_H_BURST_LEN,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int V_ACT_START   = DEF_V_ACT_START,
  parameter int V_ACT_LINES   = DEF_V_ACT_LINES
) (
  input  logic          clk,
  input  logic          rst_n,
  ntsc_timing_if.master vid
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HALF_LINE = H_TOTAL / 2;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic           eol;
  logic           in_win;
  logic           line_act;
  logic           v_last;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_line;
  logic           sync_next;
  logic           burst_next;
  logic           fs_next;
  line_type_t     lt;
  int             v;
  int             h;

  ntsc_hcount #(
    .H_TOTAL    (H_TOTAL),
    .H_ACT_START(H_ACT_START),
    .H_ACT_PIX  (H_ACT_PIX),
    .CLK_DIV    (CLK_DIV),
    .HW         (HW)
  ) u_hcount (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_act(line_act),
    .h_cnt   (h_cnt),
    .eol     (eol),
    .in_win  (in_win),
    .x_next  (x_next)
  );

  // Per-line decode: line type, active-line flag and row index.
  always_comb begin
    v        = int'(v_cnt);
    v_last   = (v == V_TOTAL - 1);
    line_act = (v >= V_ACT_START) && (v < V_ACT_START + V_ACT_LINES);
    y_line   = Y_W'(v - V_ACT_START);
    if (v <= 2 || (v >= 6 && v <= 8)) begin
      lt = LT_EQ;
    end else if (v >= 3 && v <= 5) begin
      lt = LT_VS;
    end else begin
      lt = LT_NORMAL;
    end
  end

  // Sync, burst and frame-strobe compares for the current position.
  always_comb begin
    h          = int'(h_cnt);
    sync_next  = 1'b1;
    burst_next = 1'b0;
    fs_next    = (h == 0) && (v == 0);
    case (lt)
      LT_EQ:     sync_next = !((h < H_EQ) ||
                               (h >= HALF_LINE && h < HALF_LINE + H_EQ));
      LT_VS:     sync_next = !((h < HALF_LINE - H_SYNC) ||
                               (h >= HALF_LINE && h < H_TOTAL - H_SYNC));
      LT_NORMAL: sync_next = !(h < H_SYNC);
      default:   sync_next = 1'b1;
    endcase
`ifdef NTSC_TIMING_BURST_EN
    burst_next = (lt == LT_NORMAL) && (h >= H_BURST_START) &&
                 (h < H_BURST_START + H_BURST_LEN);
`else
    burst_next = 1'b0;
`endif
  end

  // Line counter and registered outputs; x, y and active_video move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_cnt            <= '0;
      vid.x            <= '0;
      vid.y            <= '0;
      vid.active_video <= 1'b0;
      vid.sync_n       <= 1'b1;
      vid.burst_gate   <= 1'b0;
      vid.frame_start  <= 1'b0;
    end else begin
      if (eol) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
      vid.x            <= x_next;
      vid.y            <= in_win ? y_line : '0;
      vid.active_video <= in_win;
      vid.sync_n       <= sync_next;
      vid.burst_gate   <= burst_next;
      vid.frame_start  <= fs_next;
    end
  end

endmodule
